msg_loader: RTL

- Write-side counterpart of the hash generator's message fetch. Accepts a stream of 32-bit message words over a valid/ready handshake and writes them into the 16x32 message memory.
- Zero-fills any unused tail words, then pulses start to the hash generator.
- While the hash is being computed, releases the memory port to the hash generator. Waits for the generator's done indication before accepting the next message.

---
 rtl/msg_loader.sv | 68 ++++++
 1 files changed

// File: rtl/msg_loader.sv
// msg_loader: streams message words into the hash message memory, zero-fills the tail, then hands the port to the hash generator
module msg_loader #(
    parameter int WORDS  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wordIn,
    input  logic              wordValid,
    input  logic              wordLast,
    output logic              wordReady,
    output logic [ADDR_W-1:0] memAddress,
    output logic [DATA_W-1:0] memData,
    output logic              memRw,
    output logic              memOwn,
    output logic              hashStart,
    input  logic              hashDone,
    output logic              busy
);
    localparam logic [1:0] LOAD  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] START = 2'd2;
    localparam logic [1:0] WAIT  = 2'd3;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(WORDS - 1);
    logic [1:0] state;
    logic [ADDR_W-1:0] cnt;
    logic accept;
    logic at_end;
    // memory port and handshake decode; a write happens on an accepted word or on every FILL cycle
    always_comb begin
        wordReady  = state == LOAD;
        accept     = wordValid & wordReady;
        at_end     = cnt == LAST;
        memOwn     = state == LOAD || state == FILL;
        memAddress = cnt;
        memRw      = !(accept || state == FILL);
        memData    = accept ? wordIn : '0;
        hashStart  = state == START;
    end
    // sequencing: load words, pad with zeros up to the last address, start the hash, wait for it to finish
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= LOAD;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                LOAD: if (accept) begin
                    busy <= 1'b1;
                    if (at_end) state <= START;
                    else begin
                        cnt <= cnt + 1'b1;
                        if (wordLast) state <= FILL;
                    end
                end
                FILL: if (at_end) state <= START;
                      else cnt <= cnt + 1'b1;
                START: state <= WAIT;
                default: if (hashDone) begin
                    state <= LOAD;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
